// File: rtl/store_unit.sv
// Store execution unit: turns one decoded store into a word-aligned, byte-strobed memory write.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned sh/sw fault (cause 2) instead of force-aligning.

package instr_type;
  typedef enum logic [1:0] {
    sk_sb      = 2'd0,
    sk_sh      = 2'd1,
    sk_sw      = 2'd2,
    sk_invalid = 2'd3
  } store_kind_t;
endpackage

module store_unit
  import instr_type::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  store_kind_t           req_kind,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_cause
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    we_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [31:0]             wdata_next;
  logic [3:0]              wstrb_next;
  logic                    done_next;
  logic                    fault_next;
  logic [1:0]              cause_next;
  logic                    misalign;
  logic [3:0]              sb_strb;
  logic [3:0]              sh_strb;

  assign req_ready = rst && (state_reg == IDLE);

  assign sb_strb = 4'b0001 << req_addr[1:0];
  assign sh_strb = 4'b0011 << {req_addr[1], 1'b0};

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = ((req_kind == sk_sh) && req_addr[0]) ||
                    ((req_kind == sk_sw) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mem_we      <= we_next;
      mem_addr    <= addr_next;
      mem_wdata   <= wdata_next;
      mem_wstrb   <= wstrb_next;
      done        <= done_next;
      fault       <= fault_next;
      fault_cause <= cause_next;
    end
  end

  // done/fault/cause are registered on entry to RESP so they coincide with that state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = mem_we;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    wstrb_next = mem_wstrb;
    done_next  = 1'b0;
    fault_next = 1'b0;
    cause_next = 2'd0;

    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_kind == sk_invalid) begin
            state_next = RESP;
            done_next  = 1'b1;
            fault_next = 1'b1;
            cause_next = 2'd1;
          end else if (misalign) begin
            state_next = RESP;
            done_next  = 1'b1;
            fault_next = 1'b1;
            cause_next = 2'd2;
          end else begin
            state_next = WAIT;
            cnt_next   = '0;
            we_next    = 1'b1;
            addr_next  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            case (req_kind)
              sk_sb: begin
                wstrb_next = sb_strb;
                wdata_next = {4{req_data[7:0]}};
              end
              sk_sh: begin
                wstrb_next = sh_strb;
                wdata_next = {2{req_data[15:0]}};
              end
              default: begin
                wstrb_next = 4'b1111;
                wdata_next = req_data;
              end
            endcase
          end
        end
      end

      WAIT: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_next = RESP;
          we_next    = 1'b0;
          done_next  = 1'b1;
        end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_next = RESP;
          we_next    = 1'b0;
          done_next  = 1'b1;
          fault_next = 1'b1;
          cause_next = 2'd3;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RESP: begin
        state_next = IDLE;
        cnt_next   = '0;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        we_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit.
module tb_store_unit;
  import instr_type::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  store_kind_t req_kind;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        done;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int passes = 0;

  store_unit #(.ADDR_WIDTH(32), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_addr(req_addr), .req_data(req_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .done(done), .fault(fault), .fault_cause(fault_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic issue(input store_kind_t k, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = k;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_kind = sk_sb; req_addr = '0; req_data = '0; mem_ack = 1'b0;
    #3;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, mem_wstrb, done, fault, fault_cause} !== 73'd0)
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h strb=%b done=%b fault=%b cause=%0d, expected all 0",
               mem_we, mem_addr, mem_wdata, mem_wstrb, done, fault, fault_cause);
    else passes++;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", req_ready);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", req_ready);
    else passes++;
    $display("test_reset: ready=%b", req_ready);
  endtask

  task automatic test_sb();
    issue(sk_sb, 32'h0000_1003, 32'hAABB_CCDD);
    checks++;
    if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD})
      $display("FAIL sb_write: we=%b addr=%h strb=%b wdata=%h expected 1 00001000 1000 dddddddd",
               mem_we, mem_addr, mem_wstrb, mem_wdata);
    else passes++;
    checks++;
    if (req_ready !== 1'b0) $display("FAIL sb_busy_ready: got %b expected 0", req_ready);
    else passes++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, fault, fault_cause, mem_we} !== 5'b1_0_00_0)
      $display("FAIL sb_done: done=%b fault=%b cause=%0d we=%b expected 1 0 0 0", done, fault, fault_cause, mem_we);
    else passes++;
    @(negedge clk);
    checks++;
    if ({done, req_ready} !== 2'b01)
      $display("FAIL sb_done_pulse: done=%b ready=%b expected 0 1", done, req_ready);
    else passes++;
    $display("test_sb: addr=%h strb=%b wdata=%h", mem_addr, mem_wstrb, mem_wdata);
  endtask

  task automatic test_sh_delayed_ack();
    int we_cycles;
    int stable_bad;
    we_cycles = 0;
    stable_bad = 0;
    issue(sk_sh, 32'h0000_2002, 32'h1234_5678);
    checks++;
    if ({mem_wstrb, mem_wdata, mem_addr} !== {4'b1100, 32'h5678_5678, 32'h0000_2000})
      $display("FAIL sh_write: strb=%b wdata=%h addr=%h expected 1100 56785678 00002000",
               mem_wstrb, mem_wdata, mem_addr);
    else passes++;
    // A request presented while busy must be ignored.
    req_valid = 1'b1; req_kind = sk_sb; req_addr = 32'h0000_9001; req_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      if (mem_we) we_cycles++;
      if ({mem_wstrb, mem_wdata, mem_addr} !== {4'b1100, 32'h5678_5678, 32'h0000_2000}) stable_bad++;
      if (i == 3) req_valid = 1'b0;
      if (i == 5) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if (we_cycles !== 6) $display("FAIL sh_we_cycles: got %0d expected 6", we_cycles);
    else passes++;
    checks++;
    if (stable_bad !== 0) $display("FAIL sh_hold_stable: %0d unstable cycles expected 0", stable_bad);
    else passes++;
    checks++;
    if ({done, fault, mem_we} !== 3'b100)
      $display("FAIL sh_done: done=%b fault=%b we=%b expected 1 0 0", done, fault, mem_we);
    else passes++;
    @(negedge clk);
    $display("test_sh_delayed_ack: we_cycles=%0d", we_cycles);
  endtask

  task automatic test_invalid();
    // Stray ack while idle must not produce anything.
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({mem_we, done} !== 2'b00) $display("FAIL idle_ack_ignored: we=%b done=%b expected 0 0", mem_we, done);
    else passes++;
    issue(sk_invalid, 32'h0000_5555, 32'h0123_4567);
    checks++;
    if ({mem_we, done, fault, fault_cause} !== 5'b0_1_1_01)
      $display("FAIL invalid_resp: we=%b done=%b fault=%b cause=%0d expected 0 1 1 1",
               mem_we, done, fault, fault_cause);
    else passes++;
    @(negedge clk);
    checks++;
    if ({mem_we, done, fault, req_ready} !== 4'b0001)
      $display("FAIL invalid_after: we=%b done=%b fault=%b ready=%b expected 0 0 0 1",
               mem_we, done, fault, req_ready);
    else passes++;
    $display("test_invalid: cause=1 path");
  endtask

  task automatic test_misaligned_sw();
    issue(sk_sw, 32'h0000_3001, 32'hCAFE_F00D);
`ifdef STORE_MISALIGN_TRAP_EN
    checks++;
    if ({mem_we, done, fault, fault_cause} !== 5'b0_1_1_10)
      $display("FAIL sw_misalign_trap: we=%b done=%b fault=%b cause=%0d expected 0 1 1 2",
               mem_we, done, fault, fault_cause);
    else passes++;
    @(negedge clk);
`else
    checks++;
    if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D})
      $display("FAIL sw_force_align: we=%b addr=%h strb=%b wdata=%h expected 1 00003000 1111 cafef00d",
               mem_we, mem_addr, mem_wstrb, mem_wdata);
    else passes++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, fault, fault_cause} !== 4'b1_0_00)
      $display("FAIL sw_force_align_done: done=%b fault=%b cause=%0d expected 1 0 0", done, fault, fault_cause);
    else passes++;
    @(negedge clk);
`endif
    $display("test_misaligned_sw: addr=00003001");
  endtask

  task automatic test_timeout();
    int we_cycles;
    we_cycles = 0;
    issue(sk_sw, 32'h0000_4000, 32'h5A5A_A5A5);
    for (int i = 0; i < 16; i++) begin
      if (mem_we) we_cycles++;
      checks++;
      if (done !== 1'b0) $display("FAIL timeout_early_done: cycle %0d done=%b expected 0", i, done);
      else passes++;
      @(negedge clk);
    end
    checks++;
    if (we_cycles !== 16) $display("FAIL timeout_we_cycles: got %0d expected 16", we_cycles);
    else passes++;
    checks++;
    if ({done, fault, fault_cause, mem_we} !== 5'b1_1_11_0)
      $display("FAIL timeout_fault: done=%b fault=%b cause=%0d we=%b expected 1 1 3 0",
               done, fault, fault_cause, mem_we);
    else passes++;
    @(negedge clk);
    $display("test_timeout: no-ack we_cycles=%0d", we_cycles);

    issue(sk_sw, 32'h0000_4000, 32'h5A5A_A5A5);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if ({done, fault, fault_cause} !== 4'b1_0_00)
      $display("FAIL timeout_last_ack: done=%b fault=%b cause=%0d expected 1 0 0", done, fault, fault_cause);
    else passes++;
    @(negedge clk);
    $display("test_timeout: ack on final cycle");
  endtask

  task automatic test_reset_mid_wait();
    int done_seen;
    done_seen = 0;
    issue(sk_sw, 32'h0000_6000, 32'h1111_2222);
    checks++;
    if (mem_we !== 1'b1) $display("FAIL midwait_we_before: got %b expected 1", mem_we);
    else passes++;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_we, req_ready} !== 2'b00)
      $display("FAIL midwait_async: we=%b ready=%b expected 0 0", mem_we, req_ready);
    else passes++;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) done_seen++;
    checks++;
    if (done_seen !== 0) $display("FAIL midwait_no_done: saw %0d done cycles expected 0", done_seen);
    else passes++;
    checks++;
    if ({req_ready, mem_we} !== 2'b10)
      $display("FAIL midwait_recover_ready: ready=%b we=%b expected 1 0", req_ready, mem_we);
    else passes++;
    issue(sk_sw, 32'h0000_7004, 32'h0BAD_BEEF);
    checks++;
    if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h0000_7004, 4'b1111, 32'h0BAD_BEEF})
      $display("FAIL midwait_new_sw: we=%b addr=%h strb=%b wdata=%h expected 1 00007004 1111 0badbeef",
               mem_we, mem_addr, mem_wstrb, mem_wdata);
    else passes++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, fault} !== 2'b10) $display("FAIL midwait_new_done: done=%b fault=%b expected 1 0", done, fault);
    else passes++;
    @(negedge clk);
    $display("test_reset_mid_wait: recovered");
  endtask

  task automatic test_back_to_back();
    issue(sk_sh, 32'h0000_8001, 32'hABCD_EF01);
    checks++;
    if ({mem_wstrb, mem_wdata, mem_addr} !== {4'b0011, 32'hEF01_EF01, 32'h0000_8000})
      $display("FAIL b2b_sh_low: strb=%b wdata=%h addr=%h expected 0011 ef01ef01 00008000",
               mem_wstrb, mem_wdata, mem_addr);
    else passes++;
    // Keep a second request pending; it may only be taken once the unit is back in IDLE.
    req_valid = 1'b1; req_kind = sk_sb; req_addr = 32'h0000_8002; req_data = 32'h0000_0077;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({done, req_ready} !== 2'b10) $display("FAIL b2b_resp: done=%b ready=%b expected 1 0", done, req_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL b2b_idle_ready: got %b expected 1", req_ready);
    else passes++;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({mem_we, mem_wstrb, mem_wdata} !== {1'b1, 4'b0100, 32'h7777_7777})
      $display("FAIL b2b_second: we=%b strb=%b wdata=%h expected 1 0100 77777777",
               mem_we, mem_wstrb, mem_wdata);
    else passes++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    $display("test_back_to_back: second accept 3 cycles after first");
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh_delayed_ack();
    test_invalid();
    test_misaligned_sw();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
